// File: rtl/instruction_fetch_stage_if.sv
// Bundle of the fetch-stage control inputs, memory data and IF/ID outputs.
// master: hazard unit / EXE / instruction memory side. slave: the IF stage.
interface instruction_fetch_stage_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              freeze;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic [31:0]       instr_in;
    logic [ADDR_W-1:0] pc_out;
    logic [ADDR_W-1:0] if_id_pc;
    logic [31:0]       if_id_instr;
    logic              if_id_valid;
    logic              addr_fault;
    logic [31:0]       fetch_count;

    modport master (
        output freeze, branch_taken, branch_target, instr_in,
        input  pc_out, if_id_pc, if_id_instr, if_id_valid, addr_fault, fetch_count
    );

    modport slave (
        input  freeze, branch_taken, branch_target, instr_in,
        output pc_out, if_id_pc, if_id_instr, if_id_valid, addr_fault, fetch_count
    );
endinterface

// File: rtl/instruction_fetch_stage.sv
// IF stage: owns the PC, addresses a word-indexed instruction memory and
// registers the fetched word plus PC+1 into IF/ID. Redirects beat stalls;
// out-of-range PCs park and raise a sticky fault instead of fetching.
module instruction_fetch_stage #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int unsigned       MEM_DEPTH = 100,
    parameter logic [31:0]       NOP_WORD  = 32'h0000_0000
) (
    input logic                      clk,
    input logic                      rst,
    instruction_fetch_stage_if.slave bus
);

    // One extra bit so the limit is representable even when it equals 2^ADDR_W.
    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W + 1)'(MEM_DEPTH);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_if_id_pc;
    logic [31:0]       r_if_id_instr;
    logic              r_if_id_valid;
    logic              r_addr_fault;
    logic [31:0]       r_fetch_count;

    logic [ADDR_W-1:0] w_pc_plus1;
    logic [ADDR_W-1:0] w_pc_next;
    logic              w_out_of_range;

    // Next-PC selection: redirect, then hold on stall or illegal PC, else advance.
    always_comb begin
        w_pc_plus1     = r_pc + ADDR_W'(1);
        w_out_of_range = ({1'b0, r_pc} >= MEM_LIMIT);
        w_pc_next      = w_pc_plus1;
        if (bus.branch_taken) begin
            w_pc_next = bus.branch_target;
        end else if (bus.freeze || w_out_of_range) begin
            w_pc_next = r_pc;
        end
    end

    // All sequential state: PC, IF/ID register, sticky fault and fetch counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc          <= RESET_PC;
            r_if_id_pc    <= '0;
            r_if_id_instr <= NOP_WORD;
            r_if_id_valid <= 1'b0;
            r_addr_fault  <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            r_pc <= w_pc_next;
            if (bus.branch_taken) begin
                // Flush the wrong-path word already sitting in IF.
                r_if_id_pc    <= '0;
                r_if_id_instr <= NOP_WORD;
                r_if_id_valid <= 1'b0;
            end else if (bus.freeze) begin
                r_if_id_pc    <= r_if_id_pc;
                r_if_id_instr <= r_if_id_instr;
                r_if_id_valid <= r_if_id_valid;
            end else if (w_out_of_range) begin
                // Never forward the word read from an illegal address.
                r_if_id_pc    <= '0;
                r_if_id_instr <= NOP_WORD;
                r_if_id_valid <= 1'b0;
                r_addr_fault  <= 1'b1;
            end else begin
                r_if_id_pc    <= w_pc_plus1;
                r_if_id_instr <= bus.instr_in;
                r_if_id_valid <= 1'b1;
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

    assign bus.pc_out      = r_pc;
    assign bus.if_id_pc    = r_if_id_pc;
    assign bus.if_id_instr = r_if_id_instr;
    assign bus.if_id_valid = r_if_id_valid;
    assign bus.addr_fault  = r_addr_fault;
    assign bus.fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed scenarios followed by random
// freeze/branch traffic, all compared against a rule-level fetch model.
module tb_instruction_fetch_stage;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DEPTH  = 100;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int checks = 0;
    int errors = 0;

    // Backing store larger than the legal range so illegal reads return real junk.
    logic [31:0] mem [0:255];

    // Reference model state.
    logic [31:0] m_pc;
    logic [31:0] m_ifpc;
    logic [31:0] m_instr;
    logic        m_valid;
    logic        m_fault;
    logic [31:0] m_count;

    instruction_fetch_stage_if #(.ADDR_W(ADDR_W)) bus ();

    instruction_fetch_stage #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (32'd0),
        .MEM_DEPTH(DEPTH),
        .NOP_WORD (32'h0000_0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    assign bus.instr_in = (bus.pc_out < 32'd256) ? mem[bus.pc_out[7:0]]
                                                 : (32'hBAD0_0000 ^ bus.pc_out);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'd0;
        m_ifpc  = 32'd0;
        m_instr = 32'd0;
        m_valid = 1'b0;
        m_fault = 1'b0;
        m_count = 32'd0;
    endtask

    // One clock edge worth of the fetch rules, first match wins.
    task automatic model_edge(input logic fz, input logic br, input logic [31:0] tgt);
        if (br) begin
            m_pc    = tgt;
            m_ifpc  = 32'd0;
            m_instr = 32'd0;
            m_valid = 1'b0;
        end else if (fz) begin
            // everything holds
        end else if (m_pc >= DEPTH) begin
            m_ifpc  = 32'd0;
            m_instr = 32'd0;
            m_valid = 1'b0;
            m_fault = 1'b1;
        end else begin
            m_instr = mem[m_pc];
            m_pc    = m_pc + 32'd1;
            m_ifpc  = m_pc;
            m_valid = 1'b1;
            m_count = m_count + 32'd1;
        end
    endtask

    task automatic compare_all(input string where);
        check({where, ".pc"},    bus.pc_out,      m_pc);
        check({where, ".ifpc"},  bus.if_id_pc,    m_ifpc);
        check({where, ".instr"}, bus.if_id_instr, m_instr);
        check({where, ".valid"}, bus.if_id_valid, m_valid);
        check({where, ".fault"}, bus.addr_fault,  m_fault);
        check({where, ".count"}, bus.fetch_count, m_count);
    endtask

    task automatic step(input string where, input logic fz, input logic br,
                        input logic [31:0] tgt);
        bus.freeze        = fz;
        bus.branch_taken  = br;
        bus.branch_target = tgt;
        model_edge(fz, br, tgt);
        @(posedge clk);
        #1;
        bus.freeze       = 1'b0;
        bus.branch_taken = 1'b0;
        compare_all(where);
    endtask

    initial begin
        logic [31:0] saved_instr;
        logic [31:0] cnt0;
        int          bubbles;

        for (int i = 0; i < 256; i++) mem[i] = $urandom | 32'h0100_0000;
        bus.freeze        = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'd0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // Free run from 0
        step("run1", 1'b0, 1'b0, 32'd0);
        check("e1_pc", bus.pc_out, 32'd1);
        check("e1_instr", bus.if_id_instr, mem[0]);
        check("e1_ifpc", bus.if_id_pc, 32'd1);
        check("e1_valid", bus.if_id_valid, 1'b1);
        step("run2", 1'b0, 1'b0, 32'd0);
        step("run3", 1'b0, 1'b0, 32'd0);
        check("e3_pc", bus.pc_out, 32'd3);
        check("e3_instr", bus.if_id_instr, mem[2]);
        check("e3_count", bus.fetch_count, 32'd3);
        step("run4", 1'b0, 1'b0, 32'd0);
        step("run5", 1'b0, 1'b0, 32'd0);

        // Freeze two cycles at pc=5
        saved_instr = bus.if_id_instr;
        cnt0        = bus.fetch_count;
        step("frz1", 1'b1, 1'b0, 32'd0);
        check("frz1_pc", bus.pc_out, 32'd5);
        check("frz1_instr", bus.if_id_instr, saved_instr);
        step("frz2", 1'b1, 1'b0, 32'd0);
        check("frz2_pc", bus.pc_out, 32'd5);
        check("frz2_instr", bus.if_id_instr, saved_instr);
        step("rel", 1'b0, 1'b0, 32'd0);
        check("rel_pc", bus.pc_out, 32'd6);
        check("rel_count", bus.fetch_count, cnt0 + 32'd1);

        // Branch with simultaneous freeze at pc=44
        step("to44", 1'b0, 1'b1, 32'd44);
        step("brfz", 1'b1, 1'b1, 32'd39);
        check("brfz_pc", bus.pc_out, 32'd39);
        check("brfz_valid", bus.if_id_valid, 1'b0);
        check("brfz_instr", bus.if_id_instr, 32'd0);
        step("after_br", 1'b0, 1'b0, 32'd0);
        check("after_br_instr", bus.if_id_instr, mem[39]);
        check("after_br_ifpc", bus.if_id_pc, 32'd40);

        // Run off the end of memory
        step("to95", 1'b0, 1'b1, 32'd95);
        for (int i = 0; i < 5; i++) step("to100", 1'b0, 1'b0, 32'd0);
        check("at100_pc", bus.pc_out, 32'd100);
        check("at100_fault_pre", bus.addr_fault, 1'b0);
        step("oor1", 1'b0, 1'b0, 32'd0);
        check("oor_pc", bus.pc_out, 32'd100);
        check("oor_valid", bus.if_id_valid, 1'b0);
        check("oor_fault", bus.addr_fault, 1'b1);
        step("oor2", 1'b0, 1'b0, 32'd0);
        step("back0", 1'b0, 1'b1, 32'd0);
        step("resume", 1'b0, 1'b0, 32'd0);
        check("resume_pc", bus.pc_out, 32'd1);
        check("resume_valid", bus.if_id_valid, 1'b1);
        check("resume_fault", bus.addr_fault, 1'b1);

        // Out-of-range branch target is accepted, then parked
        step("tgt_oor", 1'b0, 1'b1, 32'd150);
        check("tgt_oor_pc", bus.pc_out, 32'd150);
        step("tgt_oor_hold", 1'b0, 1'b0, 32'd0);

        // Asynchronous reset mid-cycle at pc=20
        step("to15", 1'b0, 1'b1, 32'd15);
        for (int i = 0; i < 5; i++) step("to20", 1'b0, 1'b0, 32'd0);
        check("pre_rst_pc", bus.pc_out, 32'd20);
        check("pre_rst_valid", bus.if_id_valid, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("arst_pc", bus.pc_out, 32'd0);
        check("arst_valid", bus.if_id_valid, 1'b0);
        check("arst_count", bus.fetch_count, 32'd0);
        compare_all("arst");
        @(negedge clk);
        rst = 1'b1;
        step("post_rst", 1'b0, 1'b0, 32'd0);

        // Backward jump loop 53..57
        step("jmp_in", 1'b0, 1'b1, 32'd53);
        cnt0    = bus.fetch_count;
        bubbles = 0;
        for (int it = 0; it < 10; it++) begin
            for (int k = 0; k < 5; k++) begin
                step("loop", 1'b0, 1'b0, 32'd0);
                check("loop_pc", bus.pc_out, 32'd54 + 32'(k));
            end
            step("loop_jmp", 1'b0, 1'b1, 32'd53);
            if (!bus.if_id_valid) bubbles++;
        end
        check("loop_count", bus.fetch_count, cnt0 + 32'd50);
        check("loop_bubbles", 32'(bubbles), 32'd10);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic fz;
            logic br;
            fz = ($urandom_range(0, 3) == 0);
            br = ($urandom_range(0, 9) == 0);
            step("rand", fz, br, 32'($urandom_range(0, 110)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
